debounce_filter: RTL and testbench
==================================

# debounce_filter

Input conditioning stage placed directly upstream of the edge and pulse detectors. It synchronises a raw asynchronous input, rejects glitches shorter than a programmable number of cycles, and delivers a clean level that feeds the detectors' `a` input. It also produces one-cycle rise and fall strobes and keeps a saturating count of rejected glitches for debug visibility.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; legal values ≥ 2.
- `STABLE_CYCLES`, default 4: consecutive cycles a new value must persist before it is accepted; legal values ≥ 1.
- `GLITCH_W`, default 8: width of the glitch counter.
- `clk`  in  1  the single clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a`  in  1  raw input, asynchronous to `clk`.
- `clr_glitch`  in  1  synchronous clear of `glitch_cnt`.
- `level`  out  1  debounced, registered level.
- `rise`  out  1  one-cycle strobe on a 0→1 transition of `level`.
- `fall`  out  1  one-cycle strobe on a 1→0 transition of `level`.
- `glitch_cnt`  out  `GLITCH_W`  saturating count of rejected candidates.

## Operation
- **Reset.** While `rst` is high:
  - every synchroniser stage, the internal counter `cnt`, `level`, `rise`, `fall` and `glitch_cnt` are 0.
  - This takes effect immediately, with no clock edge needed.
- **Synchroniser.** `a` passes through a chain of `SYNC_STAGES` flops. `a_s` is the last stage. Nothing other than the first stage samples `a` directly.
- **Stability counter.** `cnt` is `$clog2(STABLE_CYCLES+1)` bits wide. On each edge:
  - `a_s == level`: `cnt` ← 0.
  - `a_s != level` and `cnt == STABLE_CYCLES-1`: `level` ← `a_s`, `cnt` ← 0, and `rise` ← `a_s` / `fall` ← `~a_s`.
  - `a_s != level` otherwise: `cnt` ← `cnt` + 1.
- **Strobes.** `rise` and `fall` are registered. They are 0 on every edge that does not update `level`. Each is therefore high for exactly one cycle, and they are never high together.
- **Glitch detection.** A glitch is an edge where `cnt != 0` and `a_s == level`, i.e. a candidate change is abandoned.
  - On a glitch, `glitch_cnt` increments.
  - It saturates at 2^`GLITCH_W` − 1 and does not wrap.
- **`clr_glitch`.** When high, `glitch_cnt` ← 0 on that edge. This has priority over a simultaneous glitch increment, so the result is 0.
- **`STABLE_CYCLES` = 1.** `level` follows `a_s` with one cycle of delay, `cnt` stays 0, and `glitch_cnt` never increments.
- **Reset mid-count.** A partial count is discarded. After `rst` falls, a held input must again satisfy the full latency.

## Timing
- **Acceptance latency.** Let `a` change and be stable before edge E0. Then:
  - `a_s` reflects the change after edge E(`SYNC_STAGES`−1).
  - `level`, `rise` and `fall` update at edge E(`SYNC_STAGES`+`STABLE_CYCLES`−1).
  - With defaults this is the 6th edge, E5.
- **Minimum accepted pulse.** A pulse must be stable for `STABLE_CYCLES` consecutive `a_s` samples. Anything shorter is rejected.
- **Glitch count timing.** `glitch_cnt` updates on the edge where `a_s` returns to `level`, which is `SYNC_STAGES` edges after `a` returns.
- **Reset release.** Deassertion of `rst` is assumed synchronised externally. The first functional edge is the first `clk` rising edge with `rst` low.
- **Outputs.** All outputs are flop outputs; there are no combinational paths from inputs to outputs.

## Test plan
- **Async reset.** Drive non-zero state, then assert `rst` between clock edges → `level`, `rise`, `fall` and `glitch_cnt` all read 0 before the next edge.
- **Clean rise.** Defaults; `a` goes 0→1 before E0 and is held 10 cycles → `level`=1 from E5 onward, `rise`=1 only in the cycle after E5, `fall`=0 throughout, `glitch_cnt`=0.
- **Rejected glitch.** Defaults; `a`=1 for 3 cycles, then 0 → `level` stays 0, `rise` never asserts, `glitch_cnt`=1. Repeat starting from `level`=1 with a 2-cycle low pulse → `level` stays 1, `glitch_cnt`=2.
- **Saturation.** `GLITCH_W`=2; apply 5 separate 2-cycle pulses → `glitch_cnt` reads 1, 2, 3, 3, 3.
- **Clear priority.** Assert `clr_glitch` on the same edge a glitch is detected → `glitch_cnt`=0. The next glitch → `glitch_cnt`=1.
- **Reset mid-count.** Defaults; `a` held 1, and `rst` pulsed at E3 → `level` stays 0. After release, `level` rises exactly at the 6th functional edge, `rise` is a single cycle, and a following clean fall gives `fall`=1 for one cycle.

Source files
------------

// File: rtl/debounce_filter.sv
// Input conditioning: synchronises a raw async input, rejects short glitches,
// and provides a clean level, one-cycle edge strobes and a saturating glitch count.
module debounce_filter #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a,
    input  logic                clr_glitch,
    output logic                level,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   a_s;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;

    assign a_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], a};
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = glitch_q;

        if (a_s == level_q) begin
            cnt_d = '0;
            // A non-zero count here means a candidate change was abandoned.
            if ((cnt_q != '0) && (glitch_q != '1)) begin
                glitch_d = glitch_q + GLITCH_W'(1);
            end
        end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
            level_d = a_s;
            cnt_d   = '0;
            rise_d  = a_s;
            fall_d  = ~a_s;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        if (clr_glitch) begin
            glitch_d = '0;
        end
    end

    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Directed testbench for debounce_filter: default-parameter instance plus a
// GLITCH_W=2 instance sharing the same inputs for the saturation scenario.
module tb_debounce_filter;

    logic       clk;
    logic       rst;
    logic       a;
    logic       clr_glitch;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] glitch_cnt;
    logic       level2;
    logic       rise2;
    logic       fall2;
    logic [1:0] glitch_cnt2;

    int checks;
    int errors;
    int rise_seen;
    int fall_seen;

    debounce_filter dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .clr_glitch (clr_glitch),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .glitch_cnt (glitch_cnt)
    );

    debounce_filter #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .GLITCH_W      (2)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .clr_glitch (clr_glitch),
        .level      (level2),
        .rise       (rise2),
        .fall       (fall2),
        .glitch_cnt (glitch_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n edges; leave time 1 unit after the last edge, tallying strobes.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rise) rise_seen++;
            if (fall) fall_seen++;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        a          = 1'b0;
        clr_glitch = 1'b0;
        step(3);
        rst       = 1'b0;
        rise_seen = 0;
        fall_seen = 0;
    endtask

    task automatic test_reset();
        // Build non-zero state: level=1 and one glitch recorded.
        do_reset();
        a = 1'b1;
        step(10);
        a = 1'b0;
        step(2);
        a = 1'b1;
        step(10);
        checks++;
        if (level !== 1'b1 || glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL reset_setup level=%0b glitch=%0d required level=1 glitch=1",
                     level, glitch_cnt);
        end
        // Assert reset between edges and observe before the next edge.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (level !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset level=%0b rise=%0b fall=%0b glitch=%0d required all 0",
                     level, rise, fall, glitch_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_rise();
        do_reset();
        a = 1'b1;
        step(5);
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL rise_early level=%0b after E4 required 0", level);
        end
        step(1);
        checks++;
        if (level !== 1'b1 || rise !== 1'b1) begin
            errors++;
            $display("FAIL rise_e5 level=%0b rise=%0b after E5 required 1 1", level, rise);
        end
        step(4);
        checks++;
        if (level !== 1'b1 || rise_seen != 1 || fall_seen != 0 || glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rise_hold level=%0b rises=%0d falls=%0d glitch=%0d required 1 1 0 0",
                     level, rise_seen, fall_seen, glitch_cnt);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        a = 1'b1;
        step(3);
        a = 1'b0;
        step(10);
        checks++;
        if (level !== 1'b0 || rise_seen != 0 || glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL glitch_high level=%0b rises=%0d glitch=%0d required 0 0 1",
                     level, rise_seen, glitch_cnt);
        end
        a = 1'b1;
        step(10);
        fall_seen = 0;
        a = 1'b0;
        step(2);
        a = 1'b1;
        step(10);
        checks++;
        if (level !== 1'b1 || fall_seen != 0 || glitch_cnt !== 8'd2) begin
            errors++;
            $display("FAIL glitch_low level=%0b falls=%0d glitch=%0d required 1 0 2",
                     level, fall_seen, glitch_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat [5];
        exp_sat[0] = 2'd1;
        exp_sat[1] = 2'd2;
        exp_sat[2] = 2'd3;
        exp_sat[3] = 2'd3;
        exp_sat[4] = 2'd3;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            a = 1'b1;
            step(2);
            a = 1'b0;
            step(8);
            checks++;
            if (glitch_cnt2 !== exp_sat[p] || glitch_cnt !== 8'(p + 1)) begin
                errors++;
                $display("FAIL saturate[%0d] narrow=%0d wide=%0d required %0d %0d",
                         p, glitch_cnt2, glitch_cnt, exp_sat[p], p + 1);
            end
        end
    endtask

    task automatic test_clear_priority();
        do_reset();
        a = 1'b1;
        step(2);
        a = 1'b0;
        step(8);
        checks++;
        if (glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_setup glitch=%0d required 1", glitch_cnt);
        end
        // Glitch is detected on the 5th edge after the pulse starts (E4).
        a = 1'b1;
        step(2);
        a = 1'b0;
        step(2);
        clr_glitch = 1'b1;
        step(1);
        clr_glitch = 1'b0;
        checks++;
        if (glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_priority glitch=%0d required 0", glitch_cnt);
        end
        a = 1'b1;
        step(2);
        a = 1'b0;
        step(8);
        checks++;
        if (glitch_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_next glitch=%0d required 1", glitch_cnt);
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        a = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_hold level=%0b required 0", level);
        end
        #2;
        rst       = 1'b0;
        rise_seen = 0;
        fall_seen = 0;
        step(5);
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_early level=%0b after 5 edges required 0", level);
        end
        step(1);
        checks++;
        if (level !== 1'b1 || rise !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_rise level=%0b rise=%0b after 6 edges required 1 1",
                     level, rise);
        end
        step(1);
        checks++;
        if (rise !== 1'b0 || rise_seen != 1) begin
            errors++;
            $display("FAIL mid_rst_single rise=%0b rises=%0d required 0 1", rise, rise_seen);
        end
        a = 1'b0;
        step(5);
        checks++;
        if (level !== 1'b1 || fall_seen != 0) begin
            errors++;
            $display("FAIL fall_early level=%0b falls=%0d required 1 0", level, fall_seen);
        end
        step(1);
        checks++;
        if (level !== 1'b0 || fall !== 1'b1 || rise !== 1'b0) begin
            errors++;
            $display("FAIL fall_e5 level=%0b fall=%0b rise=%0b required 0 1 0",
                     level, fall, rise);
        end
        step(4);
        checks++;
        if (fall_seen != 1 || rise_seen != 1 || glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL fall_single falls=%0d rises=%0d glitch=%0d required 1 1 0",
                     fall_seen, rise_seen, glitch_cnt);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rise_seen  = 0;
        fall_seen  = 0;
        rst        = 1'b1;
        a          = 1'b0;
        clr_glitch = 1'b0;
        #1;
        checks++;
        if (level !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state level=%0b rise=%0b fall=%0b glitch=%0d required all 0",
                     level, rise, fall, glitch_cnt);
        end
        test_reset();
        test_clean_rise();
        test_glitch();
        test_saturation();
        test_clear_priority();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
